// File: rtl/data_io_pkg.sv
// data_io_pkg: opcodes, FIFO entry layout {uio, addr, data} and clk:sck ratio
package data_io_pkg;
  localparam logic [7:0] MIST_SET_ADDRESS = 8'h01;
  localparam logic [7:0] MIST_WRITE_MEMORY = 8'h02;
  localparam logic [7:0] MIST_READ_MEMORY = 8'h03;
  localparam logic [7:0] MIST_SET_CONTROL = 8'h04;
  localparam logic [7:0] MIST_GET_DMASTATE = 8'h05;
  localparam logic [7:0] MIST_ACK_DMA = 8'h06;
  localparam logic [7:0] MIST_SET_VADJ = 8'h09;
  localparam logic [7:0] MIST_NAK_DMA = 8'h0a;
  localparam logic [7:0] UIO_FILE_TX = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX = 8'h55;
  localparam int CLK_SCK_RATIO_MIN = 4;
  function automatic int fifo_entry_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction
endpackage

// File: rtl/data_io_fifo.sv
// data_io_fifo: synchronous FIFO, push accepted when full if a pop happens the same clk
module data_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    empty = wp == rp;
    full = (wp[AW-1:0] == rp[AW-1:0]) & (wp[AW] != rp[AW]);
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/data_io_v2.sv
// data_io_v2: oversampled SPI slave decoding MiST/UIO commands into a write FIFO and a prefetching read path
module data_io_v2
  import data_io_pkg::*;
#(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_INDEX = 3,
  parameter logic [NUM_INDEX*ADDR_WIDTH-1:0] INDEX_BASE = {23'h7e0000, 23'h7dffff, 23'h7dfff0}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  ss,
  input  logic                  sdi,
  output logic                  sdo,
  output logic [31:0]           ctrl_out,
  output logic [15:0]           video_adj,
  output logic [31:0]           addr_reg,
  output logic                  addr_strobe,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_uio,
  output logic                  data_download,
  output logic                  rd_req,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  dma_ack,
  output logic [7:0]            dma_status,
  output logic                  dma_nak,
  input  logic [7:0]            status_in,
  output logic [4:0]            status_index,
  output logic                  overflow,
  output logic                  underrun
);
  localparam int EW = fifo_entry_w(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [1:0] LAST = 2'(DATA_WIDTH / 8 - 1);
  logic [1:0] sck_s, ss_s, sdi_s;
  logic sck_d, rise_q, fall_q, sdi_q, ss_q;
  logic [2:0] bit_cnt;
  logic [9:0] byte_cnt;
  logic [6:0] sr_in;
  logic [7:0] cmd, byte_in;
  logic cmd_valid, byte_done, is_wr, wr_push, pop, fifo_full, fifo_empty;
  logic [23:0] acc;
  logic [31:0] word32;
  logic [1:0] lane, rlane;
  logic [DATA_WIDTH-1:0] wbuf, word_nxt, osr, nxt, stat_w, rbuf;
  logic [ADDR_WIDTH-1:0] waddr, idx_addr;
  logic idx_hit, buf_full, rd_active, rd_phase, rd_word_start;
  logic [EW-1:0] head;
  always_comb begin
    ss_q = ss_s[1];
    byte_in = {sr_in, sdi_q};
    byte_done = rise_q & ~ss_q & (bit_cnt == 3'd7);
    word32 = {acc, byte_in};
    word_nxt = DATA_WIDTH'({wbuf, byte_in});
    is_wr = (cmd == MIST_WRITE_MEMORY) | (cmd == UIO_FILE_TX_DAT);
    wr_push = byte_done & cmd_valid & is_wr & (lane == LAST);
    wr_valid = ~fifo_empty;
    pop = wr_valid & wr_ready;
    {wr_uio, wr_addr, wr_data} = wr_valid ? head : '0;
    status_index = (byte_cnt > 10'd31) ? 5'd31 : byte_cnt[4:0];
    rlane = 2'(byte_cnt - 10'd2) & LAST;
    rd_phase = cmd_valid & (cmd == MIST_READ_MEMORY) & (byte_cnt >= 10'd2);
    rd_word_start = fall_q & ~ss_q & (bit_cnt == 3'd0) & rd_phase & (rlane == 2'd0);
    stat_w = DATA_WIDTH'(status_in) << (DATA_WIDTH - 8);
    nxt = (bit_cnt == 3'd0 && !rd_phase) ? stat_w : rd_word_start ? (buf_full ? rbuf : '1) : osr;
    idx_hit = 1'b0;
    idx_addr = '0;
    for (int i = 0; i < NUM_INDEX; i++)
      if (byte_in == 8'(i)) begin
        idx_hit = 1'b1;
        idx_addr = INDEX_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
  end
  data_io_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(wr_push), .pop(pop),
    .din({cmd == UIO_FILE_TX_DAT, waddr + ADDR_WIDTH'(1), word_nxt}),
    .dout(head), .full(fifo_full), .empty(fifo_empty)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_s <= '0;
      ss_s <= '1;
      sdi_s <= '0;
      sck_d <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      sdi_q <= 1'b0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      sr_in <= '0;
      cmd <= '0;
      cmd_valid <= 1'b0;
      acc <= '0;
      lane <= '0;
      wbuf <= '0;
      waddr <= '1;
      osr <= '0;
      sdo <= 1'b1;
      rbuf <= '0;
      buf_full <= 1'b0;
      rd_active <= 1'b0;
      ctrl_out <= '0;
      video_adj <= '0;
      addr_reg <= '0;
      addr_strobe <= 1'b0;
      rd_req <= 1'b0;
      dma_ack <= 1'b0;
      dma_nak <= 1'b0;
      dma_status <= '0;
      data_download <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], sck};
      ss_s <= {ss_s[0], ss};
      sdi_s <= {sdi_s[0], sdi};
      sck_d <= sck_s[1];
      rise_q <= sck_s[1] & ~sck_d;
      fall_q <= ~sck_s[1] & sck_d;
      sdi_q <= sdi_s[1];
      addr_strobe <= 1'b0;
      rd_req <= 1'b0;
      dma_ack <= 1'b0;
      dma_nak <= 1'b0;
      if (ss_q) begin
        bit_cnt <= '0;
        byte_cnt <= '0;
        lane <= '0;
        cmd_valid <= 1'b0;
        sdo <= 1'b1;
        rd_active <= 1'b0;
      end else if (rise_q) begin
        bit_cnt <= bit_cnt + 3'd1;
        sr_in <= byte_in[6:0];
        if (bit_cnt == 3'd7) begin
          byte_cnt <= (byte_cnt == 10'h3ff) ? byte_cnt : byte_cnt + 10'd1;
          acc <= {acc[15:0], byte_in};
          if (!cmd_valid) begin
            cmd <= byte_in;
            cmd_valid <= 1'b1;
            lane <= '0;
            dma_nak <= byte_in == MIST_NAK_DMA;
            if (byte_in == MIST_READ_MEMORY) begin
              rd_req <= 1'b1;
              rd_active <= 1'b1;
              buf_full <= 1'b0;
            end
          end else begin
            if (cmd == MIST_SET_ADDRESS && byte_cnt == 10'd4) begin
              addr_reg <= word32;
              addr_strobe <= 1'b1;
              waddr <= word32[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
            end
            if (cmd == MIST_SET_CONTROL && byte_cnt == 10'd4) ctrl_out <= word32;
            if (cmd == MIST_SET_VADJ && byte_cnt == 10'd2) video_adj <= word32[15:0];
            if (cmd == MIST_ACK_DMA) begin
              dma_ack <= 1'b1;
              dma_status <= byte_in;
            end
            if (cmd == UIO_FILE_TX) data_download <= |byte_in;
            if (cmd == UIO_FILE_INDEX && idx_hit) begin
              waddr <= idx_addr;
              overflow <= 1'b0;
            end
            if (is_wr) begin
              wbuf <= word_nxt;
              lane <= (lane == LAST) ? 2'd0 : lane + 2'd1;
              if (lane == LAST) waddr <= waddr + ADDR_WIDTH'(1);
            end
          end
        end
      end else if (fall_q) begin
        sdo <= nxt[DATA_WIDTH-1];
        osr <= nxt << 1;
        if (rd_word_start) begin
          rd_req <= 1'b1;
          buf_full <= 1'b0;
          if (!buf_full) underrun <= 1'b1;
        end
      end
      if (wr_push && fifo_full && !pop) overflow <= 1'b1;
      if (rd_valid && rd_active && !buf_full && !ss_q) begin
        rbuf <= rd_data;
        buf_full <= 1'b1;
      end
    end
  end
endmodule
